// File: rtl/udp_rx_conn_filter_pkg.sv
// ----------------------------------------------------------------------------
// udp_rx_conn_filter_pkg
//
// Shared definitions for the UDP receive connection filter.
//
// Contents:
//   HASH_WIDTH     - width of the connection-manager hash index.
//   conn_id_width  - connection ID width as a function of associativity:
//                    HASH_WIDTH + $clog2(WAYS). The connection manager uses
//                    the same helper, so both sides of the lookup channel agree.
//   lookup_key_t   - {source IPv4 address, source UDP port} lookup key.
// ----------------------------------------------------------------------------
package udp_rx_conn_filter_pkg;

    // Hash index width of the connection manager's set-associative table.
    localparam int HASH_WIDTH = 10;

    // Connection ID = {hash set index, way index}.
    function automatic int conn_id_width(input int ways);
        return HASH_WIDTH + $clog2(ways);
    endfunction

    // Key presented on the forward-lookup request channel.
    typedef struct packed {
        logic [31:0] ip_addr;
        logic [15:0] udp_port;
    } lookup_key_t;

endpackage

// File: rtl/udp_rx_conn_filter_pending_fifo.sv
// ----------------------------------------------------------------------------
// conn_filter_pending_fifo
//
// Small synchronous FIFO that holds the payload length of every descriptor
// whose forward lookup is still outstanding. Entries leave in arrival order,
// which matches the in-order responses of the connection manager.
//
// Parameters:
//   WIDTH  - entry width in bits.
//   DEPTH  - number of entries; must be a power of two, at least 2.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (empties the FIFO)
//   push       in   write push_data at the tail (caller guarantees not full)
//   push_data  in   WIDTH  data to write
//   pop        in   drop the head entry (caller guarantees not empty)
//   head       out  WIDTH  oldest entry
//   count      out  $clog2(DEPTH)+1  number of stored entries
// ----------------------------------------------------------------------------
module conn_filter_pending_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers are exactly PTR_W bits wide, so the increment wraps modulo
    // DEPTH on its own. A simultaneous push and pop leaves the count alone.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/udp_rx_conn_filter.sv
// ----------------------------------------------------------------------------
// udp_rx_conn_filter
//
// Receive-side connection filter. Every descriptor from the UDP RX header
// parser produces one forward lookup to the connection manager; the payload
// length waits in an in-order pending FIFO until the matching response comes
// back. Hits leave downstream tagged with the connection ID, misses are
// discarded. Several lookups may be in flight at once so the connection
// manager's BRAM latency does not cap throughput.
//
// Optional feature (macro UDP_RX_CONN_FILTER_DROP_CNT_EN):
//   defined   - drop_count port exists; saturating 32-bit count of misses.
//   undefined - no drop_count port; misses are dropped silently.
//
// Parameters:
//   WAYS           associativity of the connection manager (sets ID width)
//   PENDING_DEPTH  maximum outstanding lookups (power of two, >= 2)
//
// Ports:
//   s00_axis_aclk / s00_axis_areset         clock, async active-high reset
//   s00_axis_desc_*                         descriptor input {ip, port, len}
//   m00_axis_fw_lookup_*                    lookup request {ip, port}
//   s01_axis_fw_lookup_*                    lookup response {hit, connId}
//   m01_axis_desc_*                         filtered output {connId, len}
//   pending_count                           outstanding lookups
//   drop_count                              miss counter (macro only)
// ----------------------------------------------------------------------------
module udp_rx_conn_filter
    import udp_rx_conn_filter_pkg::*;
#(
    parameter  int WAYS          = 4,
    parameter  int PENDING_DEPTH = 8,
    localparam int CONN_ID_WIDTH = conn_id_width(WAYS),
    localparam int CNT_W         = $clog2(PENDING_DEPTH) + 1
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_areset,

    input  logic                     s00_axis_desc_valid,
    output logic                     s00_axis_desc_ready,
    input  logic [31:0]              s00_axis_desc_ipAddr,
    input  logic [15:0]              s00_axis_desc_udpPort,
    input  logic [15:0]              s00_axis_desc_len,

    output logic                     m00_axis_fw_lookup_valid,
    input  logic                     m00_axis_fw_lookup_ready,
    output logic [31:0]              m00_axis_fw_lookup_ipAddr,
    output logic [15:0]              m00_axis_fw_lookup_udpPort,

    input  logic                     s01_axis_fw_lookup_valid,
    output logic                     s01_axis_fw_lookup_ready,
    input  logic                     s01_axis_fw_lookup_hit,
    input  logic [CONN_ID_WIDTH-1:0] s01_axis_fw_lookup_connectionId,

    output logic                     m01_axis_desc_valid,
    input  logic                     m01_axis_desc_ready,
    output logic [CONN_ID_WIDTH-1:0] m01_axis_desc_connectionId,
    output logic [15:0]              m01_axis_desc_len,

    output logic [CNT_W-1:0]         pending_count
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
    ,
    output logic [31:0]              drop_count
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PENDING_DEPTH);

    // Request stage
    lookup_key_t req_key_q, req_key_d;
    logic        req_valid_q, req_valid_d;

    // Output stage
    logic                     out_valid_q, out_valid_d;
    logic [CONN_ID_WIDTH-1:0] out_conn_id_q, out_conn_id_d;
    logic [15:0]              out_len_q, out_len_d;

    // Pending FIFO
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      fifo_head;

    logic desc_fire;
    logic resp_fire;
    logic fifo_has_room;

    // A full FIFO stalls input even when a pop happens in the same cycle;
    // this keeps the ready path free of the response valid.
    assign fifo_has_room       = (fifo_count < DEPTH_CNT);
    assign s00_axis_desc_ready = (!req_valid_q || m00_axis_fw_lookup_ready) && fifo_has_room;
    assign desc_fire           = s00_axis_desc_valid && s00_axis_desc_ready;

    assign s01_axis_fw_lookup_ready = (fifo_count != '0) && (!out_valid_q || m01_axis_desc_ready);
    assign resp_fire                = s01_axis_fw_lookup_valid && s01_axis_fw_lookup_ready;

    // The length waits in the FIFO while the key goes out as a lookup; the
    // response pops it again in order.
    conn_filter_pending_fifo #(
        .WIDTH (16),
        .DEPTH (PENDING_DEPTH)
    ) u_pending_fifo (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .push      (desc_fire),
        .push_data (s00_axis_desc_len),
        .pop       (resp_fire),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Request register: a new descriptor may only load once the previous
    // lookup has been taken, which desc_ready already guarantees.
    always_comb begin
        req_key_d   = req_key_q;
        req_valid_d = req_valid_q;
        if (desc_fire) begin
            req_key_d.ip_addr  = s00_axis_desc_ipAddr;
            req_key_d.udp_port = s00_axis_desc_udpPort;
            req_valid_d        = 1'b1;
        end else if (m00_axis_fw_lookup_ready) begin
            req_valid_d = 1'b0;
        end
    end

    // Output register: only hits are loaded; a miss pops the FIFO and leaves
    // the register untouched.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_conn_id_d = out_conn_id_q;
        out_len_d     = out_len_q;
        if (resp_fire && s01_axis_fw_lookup_hit) begin
            out_valid_d   = 1'b1;
            out_conn_id_d = s01_axis_fw_lookup_connectionId;
            out_len_d     = fifo_head;
        end else if (m01_axis_desc_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            req_key_q     <= '0;
            req_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_conn_id_q <= '0;
            out_len_q     <= '0;
        end else begin
            req_key_q     <= req_key_d;
            req_valid_q   <= req_valid_d;
            out_valid_q   <= out_valid_d;
            out_conn_id_q <= out_conn_id_d;
            out_len_q     <= out_len_d;
        end
    end

`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
    logic [31:0] drop_count_q, drop_count_d;

    // Miss counter sticks at all-ones instead of wrapping.
    always_comb begin
        drop_count_d = drop_count_q;
        if (resp_fire && !s01_axis_fw_lookup_hit && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_d = drop_count_q + 32'd1;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign m00_axis_fw_lookup_valid   = req_valid_q;
    assign m00_axis_fw_lookup_ipAddr  = req_key_q.ip_addr;
    assign m00_axis_fw_lookup_udpPort = req_key_q.udp_port;

    assign m01_axis_desc_valid        = out_valid_q;
    assign m01_axis_desc_connectionId = out_conn_id_q;
    assign m01_axis_desc_len          = out_len_q;

    assign pending_count = fifo_count;

endmodule

// File: tb/tb_udp_rx_conn_filter.sv
// ----------------------------------------------------------------------------
// tb_udp_rx_conn_filter
//
// Self-checking bench for udp_rx_conn_filter. The bench plays the header
// parser, the connection manager and the downstream sink. Its reference is a
// transaction-level view: a list of accepted descriptors, how many lookups
// have been issued and answered, and a queue of outputs still owed.
// Also builds with UDP_RX_CONN_FILTER_DROP_CNT_EN defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_rx_conn_filter;
    import udp_rx_conn_filter_pkg::*;

    localparam int WAYS  = 4;
    localparam int DEPTH = 8;
    localparam int CID_W = conn_id_width(WAYS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0]      ip;
        logic [15:0]      port;
        logic [15:0]      len;
        logic             hit;
        logic [CID_W-1:0] cid;
        int               dly;
    } desc_t;

    typedef struct {
        logic [CID_W-1:0] cid;
        logic [15:0]      len;
    } out_t;

    logic             clk = 1'b0;
    logic             areset = 1'b1;
    logic             s00_valid = 1'b0;
    logic             s00_ready;
    logic [31:0]      s00_ip = '0;
    logic [15:0]      s00_port = '0;
    logic [15:0]      s00_len = '0;
    logic             m00_valid;
    logic             m00_ready = 1'b0;
    logic [31:0]      m00_ip;
    logic [15:0]      m00_port;
    logic             s01_valid = 1'b0;
    logic             s01_ready;
    logic             s01_hit = 1'b0;
    logic [CID_W-1:0] s01_cid = '0;
    logic             m01_valid;
    logic             m01_ready = 1'b0;
    logic [CID_W-1:0] m01_cid;
    logic [15:0]      m01_len;
    logic [CNT_W-1:0] pending_count;
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
    logic [31:0]      drop_count;
`endif

    always #5 clk = ~clk;

    udp_rx_conn_filter #(
        .WAYS          (WAYS),
        .PENDING_DEPTH (DEPTH)
    ) dut (
        .s00_axis_aclk                   (clk),
        .s00_axis_areset                 (areset),
        .s00_axis_desc_valid             (s00_valid),
        .s00_axis_desc_ready             (s00_ready),
        .s00_axis_desc_ipAddr            (s00_ip),
        .s00_axis_desc_udpPort           (s00_port),
        .s00_axis_desc_len               (s00_len),
        .m00_axis_fw_lookup_valid        (m00_valid),
        .m00_axis_fw_lookup_ready        (m00_ready),
        .m00_axis_fw_lookup_ipAddr       (m00_ip),
        .m00_axis_fw_lookup_udpPort      (m00_port),
        .s01_axis_fw_lookup_valid        (s01_valid),
        .s01_axis_fw_lookup_ready        (s01_ready),
        .s01_axis_fw_lookup_hit          (s01_hit),
        .s01_axis_fw_lookup_connectionId (s01_cid),
        .m01_axis_desc_valid             (m01_valid),
        .m01_axis_desc_ready             (m01_ready),
        .m01_axis_desc_connectionId      (m01_cid),
        .m01_axis_desc_len               (m01_len),
        .pending_count                   (pending_count)
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        ,
        .drop_count                      (drop_count)
`endif
    );

    // Reference model state
    desc_t       toSend[$];
    desc_t       acc[$];
    int          issueCyc[$];
    out_t        expOut[$];
    logic [15:0] outLens[$];
    int          sendIdx = 0;
    int          reqIdx = 0;
    int          respIdx = 0;
    int          dropModel = 0;
    int          nOut = 0;
    out_t        lastOut;
    int          stalls = 0;
    int          cyc = 0;

    // Behaviour knobs
    int cmReadyPct = 100;
    int sinkReadyPct = 100;
    int inPct = 100;
    bit respEnable = 1'b1;

    bit   prevOutStall = 1'b0;
    out_t heldOut;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic addDesc(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len,
                           input logic hit, input logic [CID_W-1:0] cid, input int dly);
        desc_t d;
        d.ip = ip; d.port = port; d.len = len; d.hit = hit; d.cid = cid; d.dly = dly;
        toSend.push_back(d);
    endtask

    // Drive all bench-owned inputs for the next cycle (called just after a rising edge).
    task automatic applyStimulus(input bit inFire, input bit respFire);
        if (inFire) sendIdx++;
        if (!(s00_valid && !inFire)) begin
            s00_valid = 1'b0;
            if (sendIdx < toSend.size() && $urandom_range(99) < inPct) begin
                s00_valid = 1'b1;
                s00_ip    = toSend[sendIdx].ip;
                s00_port  = toSend[sendIdx].port;
                s00_len   = toSend[sendIdx].len;
            end
        end
        if (respFire || !s01_valid) begin
            s01_valid = 1'b0;
            if (respEnable && respIdx < reqIdx && respIdx < acc.size() &&
                cyc >= issueCyc[respIdx] + acc[respIdx].dly) begin
                s01_valid = 1'b1;
                s01_hit   = acc[respIdx].hit;
                s01_cid   = acc[respIdx].cid;
            end
        end
        m00_ready = ($urandom_range(99) < cmReadyPct);
        m01_ready = ($urandom_range(99) < sinkReadyPct);
    endtask

    // Observe one cycle at the falling edge, check, update the model, then drive.
    task automatic stepCycle();
        bit inFire, reqFire, respFire, outFire;
        int pend;
        @(negedge clk);
        cyc++;
        pend = acc.size() - respIdx;
        checkOutput("pending_count", 64'(pending_count), 64'(pend));
        checkOutput("desc_ready", 64'(s00_ready),
                    64'(((reqIdx >= acc.size()) || m00_ready) && (pend < DEPTH)));
        checkOutput("lookup_valid", 64'(m00_valid), 64'(reqIdx < acc.size()));
        checkOutput("resp_ready", 64'(s01_ready),
                    64'((pend != 0) && (expOut.size() == 0 || m01_ready)));
        checkOutput("out_valid", 64'(m01_valid), 64'(expOut.size() != 0));
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        checkOutput("drop_count", 64'(drop_count), 64'(dropModel));
`endif
        if (prevOutStall)
            checkOutput("out_stable", 64'({m01_cid, m01_len}), 64'({heldOut.cid, heldOut.len}));

        inFire   = s00_valid && s00_ready;
        reqFire  = m00_valid && m00_ready;
        respFire = s01_valid && s01_ready;
        outFire  = m01_valid && m01_ready;
        if (s00_valid && !s00_ready) stalls++;
        prevOutStall = m01_valid && !m01_ready;
        heldOut.cid  = m01_cid;
        heldOut.len  = m01_len;

        if (reqFire) begin
            if (reqIdx < acc.size())
                checkOutput("lookup_key", 64'({m00_ip, m00_port}), 64'({acc[reqIdx].ip, acc[reqIdx].port}));
            else
                checkOutput("lookup_spurious", 64'(1), 64'(0));
            issueCyc.push_back(cyc);
            reqIdx++;
        end
        if (outFire) begin
            if (expOut.size() != 0) begin
                checkOutput("out_data", 64'({m01_cid, m01_len}), 64'({expOut[0].cid, expOut[0].len}));
                void'(expOut.pop_front());
            end else begin
                checkOutput("out_spurious", 64'(1), 64'(0));
            end
            nOut++;
            outLens.push_back(m01_len);
            lastOut.cid = m01_cid;
            lastOut.len = m01_len;
        end
        if (respFire) begin
            if (respIdx < acc.size()) begin
                if (acc[respIdx].hit) begin
                    out_t o;
                    o.cid = acc[respIdx].cid;
                    o.len = acc[respIdx].len;
                    expOut.push_back(o);
                end else begin
                    dropModel++;
                end
            end
            respIdx++;
        end
        if (inFire && sendIdx < toSend.size()) acc.push_back(toSend[sendIdx]);

        @(posedge clk);
        #1;
        applyStimulus(inFire, respFire);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic runUntilIdle(input int budget);
        int  n;
        bit  idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            idle = (sendIdx >= toSend.size()) && (respIdx >= acc.size()) &&
                   (expOut.size() == 0) && !s00_valid;
            if (!idle) begin
                stepCycle();
                n++;
            end
        end
        if (!idle) checkOutput("idle_timeout", 64'(1), 64'(0));
    endtask

    // Asynchronous reset away from the clock edge, then check the cleared state.
    task automatic doReset();
        areset    = 1'b1;
        s00_valid = 1'b0;
        s01_valid = 1'b0;
        m00_ready = 1'b0;
        m01_ready = 1'b0;
        #1;
        checkOutput("rst_lookup_valid", 64'(m00_valid), 64'(0));
        checkOutput("rst_out_valid", 64'(m01_valid), 64'(0));
        checkOutput("rst_pending", 64'(pending_count), 64'(0));
        checkOutput("rst_desc_ready", 64'(s00_ready), 64'(1));
        checkOutput("rst_resp_ready", 64'(s01_ready), 64'(0));
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        checkOutput("rst_drop_count", 64'(drop_count), 64'(0));
`endif
        toSend.delete();
        acc.delete();
        issueCyc.delete();
        expOut.delete();
        sendIdx      = 0;
        reqIdx       = 0;
        respIdx      = 0;
        dropModel    = 0;
        prevOutStall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int dropBase;
        int expLens[5];
        logic [7:0] hitPat;
        expLens = '{1, 3, 4, 6, 8};
        hitPat  = 8'b1010_1101;  // bit i = hit for descriptor i: 1,0,1,1,0,1,0,1

        $display("[TB] start");
        doReset();
        runCycles(2);

        // Single hit
        base = nOut;
        addDesc(32'h0A00_0001, 16'd5000, 16'd64, 1'b1, CID_W'(3), 2);
        runUntilIdle(200);
        checkOutput("hit_count", 64'(nOut - base), 64'(1));
        checkOutput("hit_data", 64'({lastOut.cid, lastOut.len}), 64'({CID_W'(3), 16'd64}));
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        checkOutput("hit_drop", 64'(drop_count), 64'(0));
`endif

        // Single miss
        base = nOut;
        dropBase = dropModel;
        addDesc(32'h0A00_0002, 16'd6000, 16'd128, 1'b0, CID_W'(9), 2);
        runUntilIdle(200);
        runCycles(2);
        checkOutput("miss_count", 64'(nOut - base), 64'(0));
        checkOutput("miss_pending", 64'(pending_count), 64'(0));
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        checkOutput("miss_drop", 64'(drop_count), 64'(dropBase + 1));
`endif

        // Pipelined mix, lengths 1..8
        outLens.delete();
        stalls = 0;
        dropBase = dropModel;
        for (int i = 0; i < 8; i++)
            addDesc(32'h0A00_0100 + i, 16'd7000 + 16'(i), 16'(i + 1), hitPat[i], CID_W'(i + 16), 5);
        runUntilIdle(300);
        checkOutput("mix_out_count", 64'(outLens.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            if (i < outLens.size()) checkOutput("mix_out_len", 64'(outLens[i]), 64'(expLens[i]));
        checkOutput("mix_stalls", 64'(stalls), 64'(0));
`ifdef UDP_RX_CONN_FILTER_DROP_CNT_EN
        checkOutput("mix_drop", 64'(drop_count), 64'(dropBase + 3));
`endif

        // Full FIFO: responses withheld, 10 offered
        base = acc.size();
        respEnable = 1'b0;
        for (int i = 0; i < 10; i++)
            addDesc(32'h0B00_0000 + i, 16'd100 + 16'(i), 16'(200 + i), 1'b1, CID_W'(i), 1);
        runCycles(20);
        checkOutput("full_accepted", 64'(acc.size() - base), 64'(8));
        checkOutput("full_pending", 64'(pending_count), 64'(DEPTH));
        checkOutput("full_desc_ready", 64'(s00_ready), 64'(0));
        respEnable = 1'b1;
        runUntilIdle(400);

        // Output backpressure with 2 hits
        base = nOut;
        sinkReadyPct = 0;
        addDesc(32'h0C00_0001, 16'd1, 16'd11, 1'b1, CID_W'(21), 1);
        addDesc(32'h0C00_0002, 16'd2, 16'd22, 1'b1, CID_W'(22), 1);
        runCycles(20);
        checkOutput("bp_no_output", 64'(nOut - base), 64'(0));
        checkOutput("bp_out_valid", 64'(m01_valid), 64'(1));
        checkOutput("bp_resp_ready", 64'(s01_ready), 64'(0));
        sinkReadyPct = 100;
        runUntilIdle(200);
        checkOutput("bp_out_count", 64'(nOut - base), 64'(2));
        checkOutput("bp_last", 64'({lastOut.cid, lastOut.len}), 64'({CID_W'(22), 16'd22}));

        // Reset with 4 lookups pending
        respEnable = 1'b0;
        for (int i = 0; i < 4; i++)
            addDesc(32'h0D00_0000 + i, 16'd9, 16'(300 + i), 1'b0, CID_W'(0), 1);
        runCycles(10);
        checkOutput("pre_rst_pending", 64'(pending_count), 64'(4));
        doReset();
        respEnable = 1'b1;
        base = nOut;
        addDesc(32'h0E00_0001, 16'd4242, 16'd99, 1'b1, CID_W'(5), 3);
        runUntilIdle(200);
        checkOutput("post_rst_count", 64'(nOut - base), 64'(1));
        checkOutput("post_rst_data", 64'({lastOut.cid, lastOut.len}), 64'({CID_W'(5), 16'd99}));

        // Randomized traffic with random backpressure and lookup latency
        cmReadyPct   = 70;
        sinkReadyPct = 70;
        inPct        = 80;
        for (int i = 0; i < 300; i++)
            addDesc($urandom, 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                    CID_W'($urandom), int'($urandom_range(6)));
        runUntilIdle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
